// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: conditions the raw pins, deframes bytes and
// tracks the currently held key as the keyb_char word for memory-mapped IO.
module ps2_keyboard #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [31:0] keyb_char,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    output logic        frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic          clk_s1;
    logic          clk_s2;
    logic          dat_s1;
    logic          dat_s2;
    logic          filt;
    logic          filt_d;
    logic [FW-1:0] fcnt;
    logic          sample;

    state_t        state;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] tcnt;
    logic          ext_pend;
    logic          brk_pend;
    logic [8:0]    key_q;
    logic          tout;
    logic          frame_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // fcnt counts consecutive samples that disagree with the filtered level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt   <= 1'b1;
            filt_d <= 1'b1;
            fcnt   <= '0;
        end else begin
            filt_d <= filt;
            if (clk_s2 == filt) begin
                fcnt <= '0;
            end else if (fcnt == FMAX) begin
                filt <= clk_s2;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    assign sample    = filt_d & ~filt;
    assign tout      = (state != IDLE) && (tcnt == TMAX);
    assign frame_ok  = dat_s2 && (^{shreg, par});
    assign keyb_char = {23'b0, key_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bitcnt    <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            tcnt      <= '0;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
            key_q     <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            if (rx_valid) begin
                if (rx_byte == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else if (rx_byte == 8'hF0) begin
                    brk_pend <= 1'b1;
                end else begin
                    if (!brk_pend) begin
                        key_q <= {ext_pend, rx_byte};
                    end else if ({ext_pend, rx_byte} == key_q) begin
                        key_q <= '0;
                    end
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end
            end

            if (state == IDLE || sample) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end

            // expiry takes priority over a coincident sample event
            if (tout) begin
                state     <= IDLE;
                tcnt      <= '0;
                frame_err <= 1'b1;
                ext_pend  <= 1'b0;
                brk_pend  <= 1'b0;
            end else if (sample) begin
                unique case (state)
                    IDLE: begin
                        if (!dat_s2) begin
                            state  <= DATA;
                            bitcnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg  <= {dat_s2, shreg[7:1]};
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par   <= dat_s2;
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (frame_ok) begin
                            rx_byte  <= shreg;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            ext_pend  <= 1'b0;
                            brk_pend  <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
